// File: rtl/jtag_tap_controller.sv
// ----------------------------------------------------------------------------
// jtag_tap_controller
//   IEEE 1149.1-style TAP controller. Runs the 16-state TAP machine from tms,
//   holds the instruction register, implements the IDCODE and BYPASS data
//   registers, decodes the boundary-scan register (BSR) strobes and mode
//   controls, and muxes the selected serial path onto tdo.
//
// Ports
//   tck        in   TAP clock; every state/register update is on its rising edge
//   reset      in   synchronous active-high reset (wins over tms)
//   tms        in   test mode select
//   tdi        in   serial data in (IR, IDCODE, bypass, BSR chain input)
//   bsr_tdo    in   serial output of the external BSR chain
//   tdo        out  serial data out (combinational)
//   tdo_en     out  high in Shift-DR / Shift-IR
//   clkDR      out  BSR capture/shift enable
//   shiftDR    out  BSR shift select
//   updateDR   out  BSR update enable
//   mode       out  BSR output mux select (EXTEST)
//   enableIn   out  BSR input capture enable
//   enableOut  out  BSR output drive enable
//   tap_state  out  current TAP state code
//   ir_out     out  active (updated) instruction
// ----------------------------------------------------------------------------
module jtag_tap_controller #(
  parameter int          IR_LEN = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              tms,
  input  logic              tdi,
  input  logic              bsr_tdo,
  output logic              tdo,
  output logic              tdo_en,
  output logic              clkDR,
  output logic              shiftDR,
  output logic              updateDR,
  output logic              mode,
  output logic              enableIn,
  output logic              enableOut,
  output logic [3:0]        tap_state,
  output logic [IR_LEN-1:0] ir_out
);

  typedef enum logic [3:0] {
    S_TLR     = 4'hF,
    S_RTI     = 4'hC,
    S_SELDR   = 4'h7,
    S_CAPDR   = 4'h6,
    S_SHDR    = 4'h2,
    S_EX1DR   = 4'h1,
    S_PAUSEDR = 4'h3,
    S_EX2DR   = 4'h0,
    S_UPDDR   = 4'h5,
    S_SELIR   = 4'h4,
    S_CAPIR   = 4'hE,
    S_SHIR    = 4'hA,
    S_EX1IR   = 4'h9,
    S_PAUSEIR = 4'hB,
    S_EX2IR   = 4'h8,
    S_UPDIR   = 4'hD
  } state_t;

  localparam logic [IR_LEN-1:0] IR_EXTEST  = '0;
  localparam logic [IR_LEN-1:0] IR_SAMPLE  = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

  state_t              r_state;
  state_t              w_next;
  logic [IR_LEN-1:0]   r_ir_sr;
  logic [IR_LEN-1:0]   r_ir;
  logic [31:0]         r_id_sr;
  logic                r_byp;

  logic                w_sel_extest;
  logic                w_sel_bsr;
  logic                w_sel_id;
  logic                w_tlr_load;

  // Instruction decode; any code other than EXTEST/SAMPLE/IDCODE is BYPASS.
  assign w_sel_extest = (r_ir == IR_EXTEST);
  assign w_sel_bsr    = w_sel_extest || (r_ir == IR_SAMPLE);
  assign w_sel_id     = (r_ir == IR_IDCODE);

  // Entering Test-Logic-Reset through tms has the same register effect as reset.
  assign w_tlr_load   = reset || (w_next == S_TLR);

  // ---- state register ----
  always_ff @(posedge tck) begin
    if (reset) r_state <= S_TLR;
    else       r_state <= w_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:     w_next = tms ? S_TLR   : S_RTI;
      S_RTI:     w_next = tms ? S_SELDR : S_RTI;
      S_SELDR:   w_next = tms ? S_SELIR : S_CAPDR;
      S_CAPDR:   w_next = tms ? S_EX1DR : S_SHDR;
      S_SHDR:    w_next = tms ? S_EX1DR : S_SHDR;
      S_EX1DR:   w_next = tms ? S_UPDDR : S_PAUSEDR;
      S_PAUSEDR: w_next = tms ? S_EX2DR : S_PAUSEDR;
      S_EX2DR:   w_next = tms ? S_UPDDR : S_SHDR;
      S_UPDDR:   w_next = tms ? S_SELDR : S_RTI;
      S_SELIR:   w_next = tms ? S_TLR   : S_CAPIR;
      S_CAPIR:   w_next = tms ? S_EX1IR : S_SHIR;
      S_SHIR:    w_next = tms ? S_EX1IR : S_SHIR;
      S_EX1IR:   w_next = tms ? S_UPDIR : S_PAUSEIR;
      S_PAUSEIR: w_next = tms ? S_EX2IR : S_PAUSEIR;
      S_EX2IR:   w_next = tms ? S_UPDIR : S_SHIR;
      S_UPDIR:   w_next = tms ? S_SELDR : S_RTI;
      default:   w_next = S_TLR;
    endcase
  end

  // ---- IR / DR registers ----
  // Capture, shift and update act on the edge that ends the corresponding
  // state; pause and exit states leave every shift register untouched.
  always_ff @(posedge tck) begin
    if (w_tlr_load) begin
      r_ir_sr <= '0;
      r_ir    <= IR_IDCODE;
      r_id_sr <= IDCODE;
      r_byp   <= 1'b0;
    end else begin
      case (r_state)
        S_CAPIR: r_ir_sr <= IR_CAPTURE;
        S_SHIR:  r_ir_sr <= {tdi, r_ir_sr[IR_LEN-1:1]};
        S_UPDIR: r_ir    <= r_ir_sr;
        S_CAPDR: begin
          if (w_sel_id)        r_id_sr <= IDCODE;
          else if (!w_sel_bsr) r_byp   <= 1'b0;
        end
        S_SHDR: begin
          if (w_sel_id)        r_id_sr <= {tdi, r_id_sr[31:1]};
          else if (!w_sel_bsr) r_byp   <= tdi;
        end
        default: ;
      endcase
    end
  end

  // ---- output decode (Moore on state and active instruction) ----
  always_comb begin
    tdo       = 1'b0;
    tdo_en    = 1'b0;
    clkDR     = 1'b0;
    shiftDR   = 1'b0;
    updateDR  = 1'b0;
    mode      = w_sel_extest;
    enableOut = w_sel_extest;
    enableIn  = w_sel_bsr;
    tap_state = r_state;
    ir_out    = r_ir;
    case (r_state)
      S_SHIR: begin
        tdo    = r_ir_sr[0];
        tdo_en = 1'b1;
      end
      S_CAPDR: clkDR = w_sel_bsr;
      S_SHDR: begin
        tdo_en  = 1'b1;
        clkDR   = w_sel_bsr;
        shiftDR = 1'b1;
        if (w_sel_bsr)     tdo = bsr_tdo;
        else if (w_sel_id) tdo = r_id_sr[0];
        else               tdo = r_byp;
      end
      S_UPDDR: updateDR = w_sel_bsr;
      default: ;
    endcase
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1-style TAP controller that drives the boundary scan register chain. Runs the 16-state TAP state machine from `tms`, holds an instruction register, implements IDCODE and BYPASS data registers internally, and generates the capture/shift/update strobes and mode controls consumed by the boundary scan register. It also muxes the selected serial data path onto `tdo`.

## Interface
- `IR_LEN`, 4: instruction register width (≥2).
- `IDCODE`, 32'h1000_0001: value captured by the IDCODE register (bit 0 must be 1).
- `tck`  in  1  TAP clock, sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tms`  in  1  test mode select.
- `tdi`  in  1  serial data in; routed to IR, IDCODE, bypass and the BSR chain input.
- `bsr_tdo`  in  1  serial output of the boundary scan register chain.
- `tdo`  out  1  serial data out.
- `tdo_en`  out  1  high in Shift-DR and Shift-IR only.
- `clkDR`  out  1  BSR capture/shift enable.
- `shiftDR`  out  1  BSR shift select (high in Shift-DR).
- `updateDR`  out  1  BSR update enable.
- `mode`  out  1  BSR output mux select (high = drive scanned data to pins).
- `enableIn`  out  1  BSR input capture enable.
- `enableOut`  out  1  BSR output drive enable.
- `tap_state`  out  4  current TAP state code.
- `ir_out`  out  IR_LEN  active (updated) instruction.

## Operation
- State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions follow IEEE 1149.1 exactly on each `tck` rising edge from `tms`. From any state, five consecutive `tms`=1 cycles reach TLR.
- Instructions: EXTEST = all zeros, SAMPLE = ...01, IDCODE = ...10, BYPASS = all ones. Any other code behaves as BYPASS.
- IR shift register:
  - CapIR loads `{0..0,01}`.
  - ShIR shifts right: `tdi` enters the MSB, and bit 0 drives `tdo`.
  - UpdIR copies the shift register into `ir_out`.
- Data registers are selected by `ir_out`:
  - BSR for EXTEST and SAMPLE.
  - 32-bit IDCODE register: CapDR loads `IDCODE`; ShDR shifts right, MSB ← `tdi`.
  - 1-bit bypass register: CapDR loads 0; ShDR loads `tdi`.
- `tdo` is combinational:
  - IR bit 0 in ShIR.
  - Selected DR serial out in ShDR.
  - 0 otherwise.
- BSR strobes are Moore outputs decoded from the registered state and `ir_out`:
  - `clkDR` = (CapDR or ShDR) and BSR selected.
  - `shiftDR` = ShDR.
  - `updateDR` = UpdDR and BSR selected.
  - `mode` = `enableOut` = (`ir_out` == EXTEST).
  - `enableIn` = BSR selected.
- Reset:
  - `reset`=1 forces TLR and `ir_out` = IDCODE.
  - IR shift register clears to 0, IDCODE shift register loads `IDCODE`, bypass register clears to 0.
  - All strobes, `mode`, `enableIn`, `enableOut`, `tdo` and `tdo_en` go to 0.
- Entering TLR by `tms` has the same register effect as `reset`.

## Timing
- All state, IR and DR registers update only on the rising edge of `tck`.
- Strobes are valid for the whole cycle the state register holds the corresponding state. The BSR acts on the rising edge that ends that cycle.
- `ir_out` changes on the edge leaving UpdIR, so the new instruction is effective from the next cycle.
- Reset asserted mid-shift aborts the shift: the next edge reaches TLR, and partially shifted IR/DR contents are discarded (not transferred).
- PauseDR/PauseIR hold all shift registers unchanged. Ex2 → Shift resumes from the held contents.
- Simultaneous `reset` and any `tms` value: reset wins.

## Test plan
- Reset, then `tms`=0 for 1 cycle:
  - `tap_state`=C, `ir_out`=4'b0010, all strobes 0.
- Walk TLR→RTI→SelDR→CapDR→ShDR, then shift 32 cycles of `tdi`=0:
  - `tdo` serially emits 32'h1000_0001 LSB first.
  - `tdo_en`=1 throughout the shift.
- Load IR=4'b0000 (EXTEST) via ShIR with `tdi` bits 0,0,0,0:
  - `tdo` emits 1,0,0,0 during ShIR.
  - After UpdIR, `mode`=`enableOut`=`enableIn`=1.
  - In ShDR, `clkDR`=`shiftDR`=1 and `tdo` follows `bsr_tdo`.
  - `updateDR`=1 for exactly one cycle in UpdDR.
- Load IR=4'b0111 (undefined), then ShDR with `tdi` pattern 1,0,1:
  - `tdo` is 0,1,0 (1-cycle bypass delay).
  - `clkDR`=0.
- Hold `tms`=1 for 5 cycles starting from ShDR:
  - Reaches TLR (F).
  - `ir_out` returns to IDCODE.
- Assert `reset` for one cycle in the middle of a ShIR sequence:
  - Next state is TLR and `ir_out`=IDCODE.
  - No UpdIR occurs.
